// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 word loader slice.
package aes_pkg;

  localparam int unsigned AES_BLK_W    = 128;
  localparam int unsigned AES_WORD_W   = 32;
  localparam int unsigned AES_CORE_LAT = 11;

  typedef enum logic {
    S_FILL     = 1'b0,
    S_KEY_WAIT = 1'b1
  } loader_state_t;

endpackage

// File: rtl/aes_valid_pipe.sv
// Shift register tracking block-valid strobes through the fixed-latency core.
// 'out' is the last tap, 'any' reports whether any tap is occupied.
module aes_valid_pipe #(
  parameter int unsigned DEPTH = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic out,
  output logic any
);

  logic [DEPTH-1:0] taps;

  // Advance the valid markers one stage per clock; reset flushes all of them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      taps <= '0;
    end else begin
      taps <= (taps << 1) | DEPTH'(d);
    end
  end

  assign out = taps[DEPTH-1];
  assign any = |taps;

endmodule

// File: rtl/aes_word_loader.sv
// Word-stream feeder for the pipelined AES-128 core: assembles 4-word key and
// plaintext groups, issues blocks, and holds key changes until the pipe drains.
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int unsigned CORE_LAT = AES_CORE_LAT,
  parameter int unsigned WORD_W   = AES_WORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_is_key,
  output logic [AES_BLK_W-1:0] blk_key,
  output logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_valid,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned SH_W = AES_BLK_W - WORD_W;

  loader_state_t          state_q;
  loader_state_t          state_d;
  logic                   run_q;
  logic [1:0]             wcnt;
  logic                   kind_q;
  logic [SH_W-1:0]        shreg;
  logic [AES_BLK_W-1:0]   key_shadow;
  logic                   key_commit_q;

  logic accept;
  logic mismatch;
  logic last_word;
  logic data_done;
  logic key_done;
  logic pipe_empty;
  logic commit_now;

  // Handshake and group-completion decode.
  always_comb begin
    accept     = in_valid & in_ready;
    mismatch   = accept & (wcnt != 2'd0) & (in_is_key != kind_q);
    last_word  = accept & ~mismatch & (wcnt == 2'd3);
    data_done  = last_word & ~in_is_key;
    key_done   = last_word & in_is_key;
    // A strobe in blk_valid has not yet reached the pipe, so it counts as in flight.
    pipe_empty = ~busy & ~blk_valid;
    // Immediate commits are deferred one edge so key_shadow is already loaded.
    commit_now = key_commit_q | ((state_q == S_KEY_WAIT) & ~busy);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: park in S_KEY_WAIT while blocks under the old key drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL:     if (key_done && !pipe_empty) state_d = S_KEY_WAIT;
      S_KEY_WAIT: if (!busy)                   state_d = S_FILL;
      default:    state_d = S_FILL;
    endcase
  end

  // Output logic: accept words only after reset release and outside key wait.
  always_comb begin
    in_ready = run_q & (state_q == S_FILL);
  end

  // Word assembly, block issue, key shadow/commit and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= 1'b0;
      wcnt         <= 2'd0;
      kind_q       <= 1'b0;
      shreg        <= '0;
      key_shadow   <= '0;
      key_commit_q <= 1'b0;
      blk_key      <= '0;
      blk_data     <= '0;
      blk_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      blk_valid    <= data_done;
      key_commit_q <= key_done & pipe_empty;
      if (accept) begin
        shreg <= {shreg[SH_W-WORD_W-1:0], in_data};
        // A kind change restarts the group with this word as word 0.
        wcnt  <= mismatch ? 2'd1 : wcnt + 2'd1;
        if ((wcnt == 2'd0) || mismatch) kind_q <= in_is_key;
      end
      if (mismatch)   err        <= 1'b1;
      if (data_done)  blk_data   <= {shreg, in_data};
      if (key_done)   key_shadow <= {shreg, in_data};
      if (commit_now) blk_key    <= key_shadow;
    end
  end

  aes_valid_pipe #(
    .DEPTH(CORE_LAT)
  ) u_vpipe (
    .clk (clk),
    .rst (rst),
    .d   (blk_valid),
    .out (out_valid),
    .any (busy)
  );

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: per-cycle log of DUT outputs checked
// against a word-list reference model of groups, in-flight blocks and key commits.
module tb_aes_word_loader;

  localparam int N   = 4096;
  localparam int LAT = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_is_key;
  logic [127:0] blk_key;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         out_valid;
  logic         busy;
  logic         err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  aes_word_loader #(.CORE_LAT(LAT), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_key (in_is_key),
    .blk_key   (blk_key),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .out_valid (out_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log indexed by cycle, sampled on the falling edge.
  logic [4:0]   log_flags [N];
  logic [127:0] log_key   [N];
  logic [127:0] log_data  [N];
  always @(negedge clk) begin
    if (cyc < N) begin
      log_flags[cyc] = {blk_valid, out_valid, busy, in_ready, err};
      log_key[cyc]   = blk_key;
      log_data[cyc]  = blk_data;
    end
  end

  // Reference model: expected outputs per cycle.
  logic         exp_bv [N], exp_ov [N], exp_busy [N], exp_ready [N], exp_err [N];
  logic [127:0] exp_key [N], exp_data [N];
  logic [31:0]  grp[$];
  logic         grp_kind;
  int           last_ov = -1000;

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_bv[i] = 0; exp_ov[i] = 0; exp_busy[i] = 0; exp_ready[i] = 0;
      exp_err[i] = 0; exp_key[i] = '0; exp_data[i] = '0;
    end
  end

  // Everything from cycle 'from' on is cleared; the loader is ready after release cycle q.
  task automatic model_reset(input int from, input int q);
    for (int i = from; i < N; i++) begin
      exp_bv[i] = 0; exp_ov[i] = 0; exp_busy[i] = 0; exp_err[i] = 0;
      exp_key[i] = '0; exp_ready[i] = (i > q);
    end
    grp.delete();
    last_ov = -1000;
  endtask

  // Word w of kind k accepted on the edge following falling-edge cycle c.
  task automatic model_word(input logic [31:0] w, input logic k, input int c);
    logic [127:0] blk;
    int vis;
    if (grp.size() != 0 && k != grp_kind) begin
      for (int i = c + 1; i < N; i++) exp_err[i] = 1;
      grp.delete();
    end
    if (grp.size() == 0) grp_kind = k;
    grp.push_back(w);
    if (grp.size() == 4) begin
      blk = {grp[0], grp[1], grp[2], grp[3]};
      grp.delete();
      if (!k) begin
        exp_bv[c + 1]   = 1;
        exp_data[c + 1] = blk;
        exp_ov[c + 1 + LAT] = 1;
        for (int i = c + 2; i <= c + 1 + LAT; i++) exp_busy[i] = 1;
        last_ov = c + 1 + LAT;
      end else begin
        if (c > last_ov) begin
          vis = c + 2;
        end else begin
          vis = last_ov + 2;
          for (int i = c + 1; i <= last_ov + 1; i++) exp_ready[i] = 0;
        end
        for (int i = vis; i < N; i++) exp_key[i] = blk;
      end
    end
  endtask

  // Present a word and hold it until accepted (bounded wait).
  task automatic drive_word(input logic [31:0] w, input logic k);
    int n = 0;
    in_valid = 1'b1; in_data = w; in_is_key = k;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL handshake_timeout @%0d in_ready=%b required 1", cyc, in_ready);
    end else begin
      model_word(w, k, cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int q;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_is_key = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (in_ready !== 1'b0)  begin mismatched++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    compared++; if (blk_valid !== 1'b0) begin mismatched++; $display("FAIL reset_blk_valid got %b want 0", blk_valid); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    compared++; if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (err !== 1'b0)       begin mismatched++; $display("FAIL reset_err got %b want 0", err); end
    compared++; if (blk_key !== '0)     begin mismatched++; $display("FAIL reset_blk_key got %h want 0", blk_key); end
    compared++; if (blk_data !== '0)    begin mismatched++; $display("FAIL reset_blk_data got %h want 0", blk_data); end
    rst = 1'b1;
    q = cyc;
    model_reset(1, q);
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_known_vector();
    int t0 = cyc;
    int nbv = 0;
    logic [31:0] kw [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [31:0] dw [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    for (int i = 0; i < 4; i++) drive_word(kw[i], 1'b1);
    for (int i = 0; i < 4; i++) drive_word(dw[i], 1'b0);
    repeat (16) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL known flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL known blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (exp_bv[c]) begin
        compared++;
        if (log_data[c] !== exp_data[c]) begin mismatched++; $display("FAIL known blk_data @%0d got %h want %h", c, log_data[c], exp_data[c]); end
      end
      if (log_flags[c][4] === 1'b1) nbv++;
    end
    compared++; if (blk_key !== 128'h000102030405060708090a0b0c0d0e0f) begin mismatched++; $display("FAIL known_key_value got %h want 000102030405060708090a0b0c0d0e0f", blk_key); end
    compared++; if (blk_data !== 128'h00112233445566778899aabbccddeeff) begin mismatched++; $display("FAIL known_data_value got %h want 00112233445566778899aabbccddeeff", blk_data); end
    compared++; if (nbv != 1) begin mismatched++; $display("FAIL known_bv_count got %0d want 1", nbv); end
  endtask

  task automatic test_back_to_back();
    int t0 = cyc;
    for (int i = 0; i < 8; i++) drive_word($urandom, 1'b0);
    repeat (16) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL b2b flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL b2b blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (exp_bv[c]) begin
        compared++;
        if (log_data[c] !== exp_data[c]) begin mismatched++; $display("FAIL b2b blk_data @%0d got %h want %h", c, log_data[c], exp_data[c]); end
      end
    end
  endtask

  task automatic test_key_wait();
    int t0 = cyc;
    for (int i = 0; i < 8; i++) drive_word($urandom, 1'b0);
    for (int i = 0; i < 4; i++) drive_word($urandom, 1'b1);
    for (int i = 0; i < 4; i++) drive_word($urandom, 1'b0);
    repeat (16) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL keywait flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL keywait blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (exp_bv[c]) begin
        compared++;
        if (log_data[c] !== exp_data[c]) begin mismatched++; $display("FAIL keywait blk_data @%0d got %h want %h", c, log_data[c], exp_data[c]); end
      end
    end
  endtask

  task automatic test_mixed_group();
    int t0 = cyc;
    drive_word(32'h1, 1'b0);
    drive_word(32'h2, 1'b0);
    for (int i = 0; i < 4; i++) drive_word($urandom, 1'b1);
    for (int i = 0; i < 4; i++) drive_word($urandom, 1'b0);
    repeat (16) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL mixed flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL mixed blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (exp_bv[c]) begin
        compared++;
        if (log_data[c] !== exp_data[c]) begin mismatched++; $display("FAIL mixed blk_data @%0d got %h want %h", c, log_data[c], exp_data[c]); end
      end
    end
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL mixed_err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    int t0 = cyc;
    int r;
    int nov = 0;
    for (int i = 0; i < 4; i++) drive_word($urandom, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    repeat (2) @(negedge clk);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
    rst = 1'b1;
    model_reset(r + 1, cyc);
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midrelease_in_ready got %b want 1", in_ready); end
    repeat (14) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL midreset flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL midreset blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (log_flags[c][3] === 1'b1) nov++;
    end
    compared++; if (nov != 0) begin mismatched++; $display("FAIL midreset_out_valid_count got %0d want 0", nov); end
  endtask

  task automatic test_random_gaps();
    int t0 = cyc;
    int nbv = 0;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_word($urandom, 1'b0);
    end
    repeat (16) @(negedge clk);
    for (int c = t0; c <= cyc - 1; c++) begin
      compared++;
      if (log_flags[c] !== {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]}) begin
        mismatched++;
        $display("FAIL gaps flags{bv,ov,busy,rdy,err} @%0d got %b want %b", c, log_flags[c],
                 {exp_bv[c], exp_ov[c], exp_busy[c], exp_ready[c], exp_err[c]});
      end
      compared++;
      if (log_key[c] !== exp_key[c]) begin mismatched++; $display("FAIL gaps blk_key @%0d got %h want %h", c, log_key[c], exp_key[c]); end
      if (exp_bv[c]) begin
        compared++;
        if (log_data[c] !== exp_data[c]) begin mismatched++; $display("FAIL gaps blk_data @%0d got %h want %h", c, log_data[c], exp_data[c]); end
      end
      if (log_flags[c][4] === 1'b1) nbv++;
    end
    compared++; if (nbv != 4) begin mismatched++; $display("FAIL gaps_bv_count got %0d want 4", nbv); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_is_key = 1'b0;
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_key_wait();
    test_mixed_group();
    test_reset_mid();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Upstream feeder for the unrolled, pipelined AES-128 encryption core. Accepts a 32-bit word stream with valid/ready handshake, assembles 128-bit key and plaintext blocks, and drives the core's `ip_key`/`ip_data` inputs. Tracks blocks in flight so `out_valid` marks the cycle `encr_data_out` holds the ciphertext of an issued block. Guarantees the key never changes while blocks are in flight.

## Interface
Parameters:
- `CORE_LAT`, 11: clock cycles from `blk_data` to `encr_data_out` (add-round-key stage plus 10 rounds).
- `WORD_W`, 32: input word width. Fixed; 4 words per 128-bit block.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low (asserted when 0).
- `in_valid`  in  1  word present.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  32  word; first word of a group is bits [127:96].
- `in_is_key`  in  1  1 = key word, 0 = plaintext word.
- `blk_key`  out  128  to core `ip_key`.
- `blk_data`  out  128  to core `ip_data`.
- `blk_valid`  out  1  one-cycle strobe: `blk_data` holds a newly issued block.
- `out_valid`  out  1  `blk_valid` delayed by `CORE_LAT`; qualifies `encr_data_out`.
- `busy`  out  1  any block in flight.
- `err`  out  1  sticky; set on a mixed key/data group.

## Operation
- A word is accepted on a cycle where `in_valid && in_ready`.
- Group counter `wcnt` (2 bits) counts accepted words, 0..3, then wraps to 0.
- Kind latch: `in_is_key` is sampled on the word with `wcnt==0`.
  - If a later word in the group has a different `in_is_key`, set `err`, discard the partial group, and treat this word as word 0 of a new group of its own kind.
- Shift-in: `shreg <= {shreg[95:0], in_data}`.

States:
- `S_FILL`:
  - On the 4th data word, load `blk_data <= {shreg[95:0], in_data}` and assert `blk_valid` the next cycle. Stay in `S_FILL`; no bubble.
  - On the 4th key word, load `key_shadow`. If the pipeline is empty (`busy==0` and no `blk_valid` this cycle), commit `blk_key <= key_shadow` on the next edge and stay in `S_FILL`. Otherwise go to `S_KEY_WAIT`.
- `S_KEY_WAIT`:
  - `in_ready=0`.
  - When `busy==0`, commit `blk_key <= key_shadow` and go to `S_FILL`.
- Valid pipe: a `CORE_LAT`-deep shift register of `blk_valid`.
  - `out_valid` is its last tap.
  - `busy` is the OR of all taps.
- `blk_data`/`blk_key` hold their value between issues. The core re-encrypts stale data, but `out_valid` stays 0 for it.
- Data accepted before any key load uses key 0.

## Timing
- Reset (`rst==0` at an edge): all outputs are 0, including `in_ready`, `blk_*`, `err`, `wcnt`, and the valid pipe. State is `S_FILL`.
- `in_ready` is 1 from the first edge with `rst==1`, except in `S_KEY_WAIT`.
- `blk_valid` rises 1 cycle after the edge that accepts the 4th data word.
- `out_valid` rises exactly `CORE_LAT` cycles after `blk_valid`.
- Max throughput: one block per 4 cycles.
- A key commit occurs no earlier than the cycle after the last in-flight `out_valid`.
- Reset mid-operation: partial groups, shadow key, and in-flight valids are all discarded. `out_valid` must not assert for pre-reset blocks.
- `in_valid` with `in_ready==0`: the word is not consumed; the source must hold it.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLK_W=128`, `AES_WORD_W=32`, `AES_CORE_LAT=11`
  - state enum `loader_state_t {S_FILL, S_KEY_WAIT}`
- Sub-module `aes_valid_pipe`, parameterised depth:
  - shift register with `out` tap and `any` (OR-reduce) output
  - used for `out_valid`/`busy`

## Test plan
- Load key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data 00112233, 44556677, 8899aabb, ccddeeff -> `blk_key`=000102…0f. `blk_valid` fires once, and 11 cycles later `out_valid` is set with core output 69c4e0d86a7b0430d8cdb78070b4c55a.
- 8 back-to-back data words with `in_valid` held high -> two `blk_valid` pulses 4 cycles apart, two `out_valid` pulses 4 cycles apart, `in_ready` never low.
- Key group completes while 2 blocks are in flight -> `in_ready`=0 until `busy` falls. The new key commits one edge later, and both earlier ciphertexts match the old key.
- Data words 1,2, then a key word -> `err`=1 and stays set. The key word starts a new group, and no `blk_valid` is produced for the partial data group.
- Reset pulse 5 cycles after `blk_valid` -> no `out_valid` for that block. `in_ready`=0 during reset and 1 on the cycle after release.
- `in_valid` toggling with random gaps over 16 data words -> exactly 4 `blk_valid` pulses, and `blk_data` word order is preserved.
